cmd_driver: RTL and testbench

CMD_DRIVER -- requirements
Module: cmd_driver

---
 rtl/drv_pkg.sv | 26 ++
 rtl/cmd_fifo.sv | 52 +++++
 rtl/cmd_driver.sv | 113 +++++++++++
 tb/tb_cmd_driver.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/drv_pkg.sv
// Shared types and constants for the command driver and its FIFO.
package drv_pkg;

    // cmd value presented on the bus when no beat is being driven
    localparam logic [3:0] IDLE_CMD_DEFAULT = 4'd0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } drv_state_t;

    // One queued command as captured from the upstream port
    typedef struct packed {
        logic       burst;
        logic [3:0] len;
        logic [3:0] cmd;
        logic [3:0] adr;
        logic [3:0] data;
    } drv_entry_t;

    // Saturating increment for the beat counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: DEPTH entries, wrap-bit pointers, head visible combinationally.
module cmd_fifo
    import drv_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = drv_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_entry,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic   [AW:0]   wr_ptr;
    logic   [AW:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Reset takes priority: nothing offered during reset lands in storage
    assign do_push = push && !full && !rst;
    assign do_pop  = pop && !empty && !rst;

    // Extra pointer bit distinguishes full from empty when indices match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; push and pop on one edge both advance
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

endmodule

// File: rtl/cmd_driver.sv
// Command driver: queues upstream commands and plays them onto the bus as
// single beats or incrementing-address bursts.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | bus idle (IDLE_CMD/0/0); waiting for a queued command
//   ST_ACTIVE | a beat is on the bus; beats_left more beats of this command
module cmd_driver
    import drv_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [3:0] IDLE_CMD = IDLE_CMD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_cmd,
    input  logic [3:0]  in_adr,
    input  logic [3:0]  in_data,
    input  logic        in_burst,
    input  logic [3:0]  in_len,
    output logic [3:0]  cmd,
    output logic [3:0]  adr,
    output logic [3:0]  data,
    output logic        busy,
    output logic [15:0] sent_count
);

    drv_state_t  state;
    logic [3:0]  beats_left;
    drv_entry_t  wr_entry;
    drv_entry_t  head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign wr_entry = '{burst: in_burst, len: in_len, cmd: in_cmd,
                        adr: in_adr, data: in_data};

    // Next command is taken whenever the current one has no beats left,
    // which in ST_IDLE is always true; this chains commands with no gap
    assign pop  = !fifo_empty && (state == ST_IDLE || beats_left == 4'd0);
    assign busy = (state == ST_ACTIVE) || !fifo_empty;

    cmd_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (drv_entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (wr_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Beat sequencer with registered bus outputs and saturating beat count
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            beats_left <= 4'd0;
            cmd        <= IDLE_CMD;
            adr        <= 4'd0;
            data       <= 4'd0;
            sent_count <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cmd        <= head.cmd;
                        adr        <= head.adr;
                        data       <= head.data;
                        beats_left <= head.burst ? head.len : 4'd0;
                        state      <= ST_ACTIVE;
                        sent_count <= sat_inc16(sent_count);
                    end
                end
                ST_ACTIVE: begin
                    if (beats_left != 4'd0) begin
                        beats_left <= beats_left - 4'd1;
                        adr        <= adr + 4'd1;
                        sent_count <= sat_inc16(sent_count);
                    end else if (!fifo_empty) begin
                        cmd        <= head.cmd;
                        adr        <= head.adr;
                        data       <= head.data;
                        beats_left <= head.burst ? head.len : 4'd0;
                        sent_count <= sat_inc16(sent_count);
                    end else begin
                        cmd   <= IDLE_CMD;
                        adr   <= 4'd0;
                        data  <= 4'd0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    beats_left <= 4'd0;
                    cmd        <= IDLE_CMD;
                    adr        <= 4'd0;
                    data       <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_driver.sv
// Bench for cmd_driver: directed scenarios plus randomized traffic, all
// compared against a beat-list reference model.
module tb_cmd_driver;

    localparam int         DEPTH    = 4;
    localparam logic [3:0] IDLE_CMD = 4'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_cmd = '0;
    logic [3:0]  in_adr = '0;
    logic [3:0]  in_data = '0;
    logic        in_burst = 1'b0;
    logic [3:0]  in_len = '0;
    logic [3:0]  cmd;
    logic [3:0]  adr;
    logic [3:0]  data;
    logic        busy;
    logic [15:0] sent_count;

    cmd_driver #(.DEPTH(DEPTH), .IDLE_CMD(IDLE_CMD)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cmd     (in_cmd),
        .in_adr     (in_adr),
        .in_data    (in_data),
        .in_burst   (in_burst),
        .in_len     (in_len),
        .cmd        (cmd),
        .adr        (adr),
        .data       (data),
        .busy       (busy),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: accepted commands wait in mq; the command being played
    // is expanded into its full list of {cmd,adr,data} beats in bq.
    typedef struct {
        logic [3:0] c;
        logic [3:0] a;
        logic [3:0] d;
        logic [3:0] l;
        logic       b;
    } req_t;

    req_t        mq[$];
    logic [11:0] bq[$];
    logic [11:0] m_out = {IDLE_CMD, 8'h00};
    bit          m_active = 1'b0;
    int          m_count = 0;
    bit          cov[16][16];
    bit          cov_en = 1'b0;

    function automatic req_t mk(input int c, input int a, input int d, input bit b, input int l);
        req_t r;
        r.c = 4'(c); r.a = 4'(a); r.d = 4'(d); r.b = b; r.l = 4'(l);
        return r;
    endfunction

    function automatic req_t rand_req();
        return mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                  1'($urandom_range(0, 1)), $urandom_range(0, 15));
    endfunction

    function automatic void model_edge();
        req_t c;
        int   n;
        if (bq.size() == 0 && mq.size() > 0) begin
            c = mq.pop_front();
            n = c.b ? int'(c.l) + 1 : 1;
            for (int i = 0; i < n; i++) bq.push_back({c.c, 4'(int'(c.a) + i), c.d});
        end
        if (bq.size() > 0) begin
            m_out    = bq.pop_front();
            m_active = 1'b1;
            if (m_count < 65535) m_count++;
        end else begin
            m_out    = {IDLE_CMD, 8'h00};
            m_active = 1'b0;
        end
    endfunction

    // One clock: drive inputs, advance model with the edge, check after it
    task automatic step(input bit v, input req_t r, input bit do_rst, output bit acc);
        rst      = do_rst;
        in_valid = v;
        in_cmd   = r.c;
        in_adr   = r.a;
        in_data  = r.d;
        in_burst = r.b;
        in_len   = r.l;
        acc = v && !do_rst && (mq.size() < DEPTH);
        @(posedge clk);
        if (do_rst) begin
            mq.delete();
            bq.delete();
            m_out    = {IDLE_CMD, 8'h00};
            m_active = 1'b0;
            m_count  = 0;
        end else begin
            model_edge();
            if (acc) mq.push_back(r);
        end
        @(negedge clk);
        chk("cmd",        cmd,        m_out[11:8]);
        chk("adr",        adr,        m_out[7:4]);
        chk("data",       data,       m_out[3:0]);
        chk("busy",       busy,       m_active || (mq.size() > 0));
        chk("in_ready",   in_ready,   mq.size() < DEPTH);
        chk("sent_count", sent_count, m_count);
        if (cov_en && m_active) cov[cmd][adr] = 1'b1;
    endtask

    task automatic idle_steps(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, mk(0, 0, 0, 0, 0), 1'b0, a);
    endtask

    task automatic do_reset();
        bit a;
        step(1'b1, mk(7, 7, 7, 1, 3), 1'b1, a);
        step(1'b0, mk(0, 0, 0, 0, 0), 1'b0, a);
    endtask

    initial begin
        bit   acc;
        int   idx;
        int   n_cov;
        int   tries;
        req_t pend;
        bit   pend_v;
        logic [3:0] exp_adr [4];

        // Reset, with in_valid held high during it
        step(1'b1, mk(5, 5, 5, 0, 0), 1'b1, acc);
        step(1'b1, mk(5, 5, 5, 0, 0), 1'b1, acc);
        chk("rst_cmd",   cmd,        IDLE_CMD);
        chk("rst_cnt",   sent_count, 0);
        chk("rst_busy",  busy,       0);
        chk("rst_ready", in_ready,   1);
        idle_steps(2);
        chk("rst_no_write", busy, 0);

        // Single beat: visible after the following edge, then idle
        step(1'b1, mk(3, 5, 9, 0, 6), 1'b0, acc);
        chk("single_lat_idle", cmd, IDLE_CMD);
        step(1'b0, mk(0, 0, 0, 0, 0), 1'b0, acc);
        chk("single_beat", {cmd, adr, data}, 12'h359);
        step(1'b0, mk(0, 0, 0, 0, 0), 1'b0, acc);
        chk("single_after", cmd, IDLE_CMD);
        chk("single_cnt", sent_count, 1);
        idle_steps(2);

        // Burst that wraps the address space
        do_reset();
        exp_adr[0] = 4'd14; exp_adr[1] = 4'd15; exp_adr[2] = 4'd0; exp_adr[3] = 4'd1;
        step(1'b1, mk(2, 14, 6, 1, 3), 1'b0, acc);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, mk(0, 0, 0, 0, 0), 1'b0, acc);
            chk("wrap_adr", adr, exp_adr[i]);
            chk("wrap_data", data, 6);
        end
        step(1'b0, mk(0, 0, 0, 0, 0), 1'b0, acc);
        chk("wrap_cnt", sent_count, 4);
        chk("wrap_end", busy, 0);

        // Back-to-back singles: no idle beat between them
        do_reset();
        step(1'b1, mk(1, 1, 1, 0, 0), 1'b0, acc);
        step(1'b1, mk(2, 2, 2, 0, 0), 1'b0, acc);
        chk("b2b_0", cmd, 1);
        step(1'b1, mk(3, 3, 3, 0, 0), 1'b0, acc);
        chk("b2b_1", cmd, 2);
        step(1'b0, mk(0, 0, 0, 0, 0), 1'b0, acc);
        chk("b2b_2", cmd, 3);
        idle_steps(2);

        // FIFO full while a 16-beat burst stalls the sequencer
        do_reset();
        step(1'b1, mk(9, 0, 4, 1, 15), 1'b0, acc);
        idx = 0;
        for (int j = 0; j < 60; j++) begin
            step(idx < 7, mk(idx + 1, idx, 15 - idx, 0, 0), 1'b0, acc);
            if (acc) idx++;
            if (j == 5) begin
                chk("full_ready", in_ready, 0);
                chk("full_accepted", idx, DEPTH);
            end
        end
        chk("full_all_acc", idx, 7);
        chk("full_cnt", sent_count, 16 + 7);

        // Reset on the 3rd beat of a burst with two commands queued
        do_reset();
        step(1'b1, mk(5, 2, 8, 1, 7), 1'b0, acc);
        step(1'b1, mk(6, 1, 1, 0, 0), 1'b0, acc);
        step(1'b1, mk(7, 2, 2, 0, 0), 1'b0, acc);
        step(1'b0, mk(0, 0, 0, 0, 0), 1'b0, acc);
        chk("rmb_3rd_beat", adr, 4);
        step(1'b0, mk(0, 0, 0, 0, 0), 1'b1, acc);
        chk("rmb_busy", busy, 0);
        chk("rmb_cnt", sent_count, 0);
        chk("rmb_out", {cmd, adr, data}, {IDLE_CMD, 8'h00});
        chk("rmb_ready", in_ready, 1);
        idle_steps(12);
        chk("rmb_quiet", sent_count, 0);

        // Coverage sweep: every cmd across every address
        do_reset();
        for (int i = 0; i < 16; i++) for (int k = 0; k < 16; k++) cov[i][k] = 1'b0;
        cov_en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 100) begin
                step(1'b1, mk(c, 0, c, 1, 15), 1'b0, acc);
                tries++;
            end
            chk("sweep_accept", acc, 1);
        end
        idle_steps(80);
        cov_en = 1'b0;
        n_cov = 0;
        for (int i = 0; i < 16; i++) for (int k = 0; k < 16; k++) n_cov += int'(cov[i][k]);
        chk("sweep_cov", n_cov, 256);
        chk("sweep_cnt", sent_count, 256);

        // Randomized traffic; upstream holds a refused command until taken
        do_reset();
        pend_v = 1'b0;
        pend   = mk(0, 0, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            bit r;
            r = ($urandom_range(0, 199) == 0);
            if (!pend_v) begin
                pend_v = ($urandom_range(0, 2) != 0);
                pend   = rand_req();
            end
            step(pend_v, pend, r, acc);
            if (acc || r) pend_v = 1'b0;
        end
        idle_steps(80);
        chk("final_drained", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
